// File: rtl/d_ff.sv
// Parameterized D register / delay line with complementary outputs and synchronous reset.
// Optional clock enable port `ce` is present only when D_FF_CE_EN is defined.
module d_ff #(
  parameter int unsigned       WIDTH   = 1,
  parameter int unsigned       DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  input  logic             rst
`ifdef D_FF_CE_EN
  ,
  input  logic             ce
`endif
);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic             w_advance;

`ifdef D_FF_CE_EN
  assign w_advance = ce;
`else
  assign w_advance = 1'b1;
`endif

  // NOTE: non-blocking assignments make every stage sample its neighbour's old value,
  // so the shift happens in parallel regardless of loop order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_stage[i] <= RST_VAL;
      end
    end else if (w_advance) begin
      r_stage[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  // qbar is derived from the last stage rather than its own flop, so it can never disagree with q.
  assign q    = r_stage[DEPTH-1];
  assign qbar = ~r_stage[DEPTH-1];

endmodule

// File: tb/tb_d_ff.sv
// Self-checking bench for d_ff: three configurations driven in parallel, an input-history
// model compared every cycle, plus directed checks with hand-computed values.
module tb_d_ff;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       d1;
  logic [7:0] d8;

  logic       qa, qbara, qb, qbarb;
  logic [7:0] qc, qbarc;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  d_ff #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) u_a (
    .clk(clk), .d(d1), .q(qa), .qbar(qbara), .rst(rst)
`ifdef D_FF_CE_EN
    , .ce(ce)
`endif
  );

  d_ff #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b1)) u_b (
    .clk(clk), .d(d1), .q(qb), .qbar(qbarb), .rst(rst)
`ifdef D_FF_CE_EN
    , .ce(ce)
`endif
  );

  d_ff #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h3C)) u_c (
    .clk(clk), .d(d8), .q(qc), .qbar(qbarc), .rst(rst)
`ifdef D_FF_CE_EN
    , .ce(ce)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remember the values accepted since the last reset; the output is the value
  // accepted DEPTH captures ago, or the reset value if fewer than DEPTH have been accepted.
  logic       hist1 [$];
  logic [7:0] hist8 [$];
  bit         seen_rst = 0;

  always @(posedge clk) begin
    if (rst) begin
      hist1.delete();
      hist8.delete();
      seen_rst = 1;
    end else if (ce) begin
      hist1.push_back(d1);
      hist8.push_back(d8);
      if (hist1.size() > 1) void'(hist1.pop_front());
      if (hist8.size() > 3) void'(hist8.pop_front());
    end
  end

  function automatic logic exp1(input logic rv);
    return (hist1.size() >= 1) ? hist1[hist1.size()-1] : rv;
  endfunction

  function automatic logic [7:0] exp8();
    return (hist8.size() >= 3) ? hist8[hist8.size()-3] : 8'h3C;
  endfunction

  always @(negedge clk) begin
    if (seen_rst) begin
      check("cyc_a_q",    {31'd0, qa},     {31'd0, exp1(1'b0)});
      check("cyc_a_qbar", {31'd0, qbara},  {31'd0, ~exp1(1'b0)});
      check("cyc_b_q",    {31'd0, qb},     {31'd0, exp1(1'b1)});
      check("cyc_b_qbar", {31'd0, qbarb},  {31'd0, ~exp1(1'b1)});
      check("cyc_c_q",    {24'd0, qc},     {24'd0, exp8()});
      check("cyc_c_qbar", {24'd0, qbarc},  {24'd0, ~exp8()});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; d1 = 1'b1; d8 = 8'h99;

    // Reset values
    step();
    check("rst_a_q",    {31'd0, qa},    32'd0);
    check("rst_a_qbar", {31'd0, qbara}, 32'd1);
    check("rst_b_q",    {31'd0, qb},    32'd1);
    check("rst_b_qbar", {31'd0, qbarb}, 32'd0);
    check("rst_c_q",    {24'd0, qc},    32'h3C);
    check("rst_c_qbar", {24'd0, qbarc}, 32'hC3);
    rst = 1'b0;

    // Capture with d held for 50 time units
    d1 = 1'b0;
    #50;
    check("cap0_q",    {31'd0, qa},    32'd0);
    check("cap0_qbar", {31'd0, qbara}, 32'd1);
    d1 = 1'b1;
    #50;
    check("cap1_q",    {31'd0, qa},    32'd1);
    check("cap1_qbar", {31'd0, qbara}, 32'd0);

    // Exactly one edge of latency
    step();
    d1 = 1'b0;
    check("lat_before", {31'd0, qa}, 32'd1);
    step();
    check("lat_after",  {31'd0, qa}, 32'd0);

    // Delay line, DEPTH=3
    d8 = 8'h11; step();
    d8 = 8'h22; step();
    d8 = 8'h33; step();
    check("dl_q_11",    {24'd0, qc},    32'h11);
    check("dl_qbar_ee", {24'd0, qbarc}, 32'hEE);
    check("model_11",   {24'd0, exp8()}, 32'h11);
    d8 = 8'h44; step();
    check("dl_q_22", {24'd0, qc}, 32'h22);
    step();
    check("dl_q_33", {24'd0, qc}, 32'h33);
    step();
    check("dl_q_44", {24'd0, qc}, 32'h44);

    // Mid-stream reset with a full pipeline; reset wins over d in the same cycle
    d8 = 8'hA5; step(); step(); step();
    check("full_a5", {24'd0, qc}, 32'hA5);
    rst = 1'b1; d1 = 1'b1; d8 = 8'h5C;
    step();
    check("mid_rst_c", {24'd0, qc}, 32'h3C);
    check("mid_rst_a", {31'd0, qa}, 32'd0);
    check("model_rst", {24'd0, exp8()}, 32'h3C);
    rst = 1'b0; d8 = 8'h77; d1 = 1'b0;
    step();
    check("rel_1", {24'd0, qc}, 32'h3C);
    step();
    check("rel_2", {24'd0, qc}, 32'h3C);
    step();
    check("rel_3", {24'd0, qc}, 32'h77);

    // Reset pulse entirely between edges has no effect
    #3 rst = 1'b1;
    #4 rst = 1'b0;
    step();
    check("pulse_c", {24'd0, qc}, 32'h77);
    check("pulse_b", {31'd0, qb}, 32'd0);

`ifdef D_FF_CE_EN
    // Enable holds all stages; reset overrides a low enable
    d8 = 8'h5A; step(); step(); step();
    check("ce_load", {24'd0, qc}, 32'h5A);
    ce = 1'b0; d8 = 8'hFF; d1 = 1'b1;
    repeat (4) step();
    check("ce_hold_c", {24'd0, qc}, 32'h5A);
    check("ce_hold_a", {31'd0, qa}, 32'd0);
    rst = 1'b1;
    step();
    check("ce_rst_c", {24'd0, qc}, 32'h3C);
    check("ce_rst_b", {31'd0, qb}, 32'd1);
    rst = 1'b0; ce = 1'b1;
    step(); step(); step();
    check("ce_resume", {24'd0, qc}, 32'hFF);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
